// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter
//   Round-robin arbiter in front of a shared 4:1 selection path. Four
//   requesters compete through req; the winner receives a one-hot gnt, its
//   index drives the internal mux select (sel), and its data is returned as
//   a registered result while it keeps requesting.
//
//   Optional feature: define ARB_TIMEOUT_EN to bound ownership. The owner is
//   then rotated out after HOLD_MAX consecutive grant cycles, but only while
//   another requester is waiting.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   req[3:0]     in   request per requester; bit i requests d_i
//   d0..d3       in   requester data, WIDTH bits each
//   gnt[3:0]     out  registered one-hot grant; 0 when idle
//   sel[1:0]     out  registered index of the current/last grant
//   busy         out  1 while a grant is held
//   result       out  registered d[sel], captured during valid grant cycles
//   result_valid out  1 the cycle after a grant cycle with req[sel]=1
module mux_4x1_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  // The hold counter is 8 bits wide, so HOLD_MAX must fit 1..255.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must lie in 1..255");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rvld_q, rvld_d;

  // Arbitration decisions shared by the next-state and output processes.
  logic             grant_new;  // load a (possibly different) winner this edge
  logic             go_idle;    // release with nobody else waiting
  logic             capture;    // owner still requesting: valid grant cycle
  logic             ptr_adv;    // owner gives up priority
  logic [1:0]       win;
  logic [1:0]       next_start;
  logic [3:0]       others;
  logic [WIDTH-1:0] dmux;

  // Winner = first set bit of r, scanning start, start+1, ... mod 4.
  // Scanning from farthest to nearest lets the nearest hit overwrite.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    case (sel_q)
      2'd0:    dmux = d0;
      2'd1:    dmux = d1;
      2'd2:    dmux = d2;
      default: dmux = d3;
    endcase
  end

  assign next_start = sel_q + 2'd1;
  assign others     = req & ~(4'b0001 << sel_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout;
  assign timeout = (hold_cnt_q == HOLD_LAST) && (others != 4'b0000);
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  // Next-state process: who wins, and where the FSM goes.
  always_comb begin
    state_d   = state_q;
    grant_new = 1'b0;
    go_idle   = 1'b0;
    capture   = 1'b0;
    ptr_adv   = 1'b0;
    win       = sel_q;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          grant_new = 1'b1;
          win       = pick(req, ptr_q);
          state_d   = GRANT;
        end
      end
      default: begin
        if (req[sel_q]) begin
          capture = 1'b1;
          // Forced rotation still counts this cycle as a valid grant cycle.
          if (timeout) begin
            grant_new = 1'b1;
            ptr_adv   = 1'b1;
            win       = pick(others, next_start);
          end
        end else begin
          // Owner released; req equals others here, hand over without a bubble.
          ptr_adv = 1'b1;
          if (req != 4'b0000) begin
            grant_new = 1'b1;
            win       = pick(req, next_start);
          end else begin
            go_idle = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Output process: next values of the registered outputs and pointer.
  always_comb begin
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    rvld_d   = capture;
    if (grant_new) begin
      gnt_d = 4'b0001 << win;
      sel_d = win;
    end else if (go_idle) begin
      gnt_d = 4'b0000;
    end
    if (ptr_adv) ptr_d = next_start;
    if (capture) result_d = dmux;
  end

`ifdef ARB_TIMEOUT_EN
  // Counts consecutive owner cycles; saturates when nobody is waiting.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (grant_new) hold_cnt_d = 8'd0;
    else if (capture && hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt_q <= 8'd0;
    else     hold_cnt_q <= hold_cnt_d;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      ptr_q    <= 2'd0;
      result_q <= '0;
      rvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      rvld_q   <= rvld_d;
    end
  end

  assign gnt          = gnt_q;
  assign sel          = sel_q;
  assign busy         = (state_q == GRANT);
  assign result       = result_q;
  assign result_valid = rvld_q;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
module tb_mux_4x1_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] dv [4];
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  mux_4x1_rr_arbiter #(.WIDTH(W), .HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .gnt(gnt), .sel(sel), .busy(busy),
    .result(result), .result_valid(result_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  // Monitor: pops one expected result per presented result_valid.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(result), 32'hFFFF_FFFF);
        end else begin
          chk("result", 32'(result), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o;
    rst = 1'b1;
    req = 4'b0000;
    dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'h32; dv[3] = 8'h43;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_rvld", 32'(result_valid), 32'h0);

    // Single request
    rst = 1'b0;
    req = 4'b0100;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_sel", 32'(sel), 32'h2);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_rvld0", 32'(result_valid), 32'h0);
    push(8'h32);
    tick();
    chk("t1_gnt_hold", 32'(gnt), 32'h4);
    chk("t1_rvld1", 32'(result_valid), 32'h1);
    req = 4'b0000;
    tick();
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_rvld", 32'(result_valid), 32'h0);
    chk("t1_idle_result", 32'(result), 32'h32);
    chk("t1_idle_sel", 32'(sel), 32'h2);

    // Round robin with all requesting
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << o));
      chk("rr_busy", 32'(busy), 32'h1);
      req = 4'b1111;
      push(dv[o]);
      tick();
      chk("rr_gnt2", 32'(gnt), 32'(4'b0001 << o));
      push(dv[o]);
      tick();
      chk("rr_gnt3", 32'(gnt), 32'(4'b0001 << o));
      req = 4'b1111 & ~(4'b0001 << o);
      tick();
      chk("rr_rvld_drop", 32'(result_valid), 32'h0);
      chk("rr_busy_nobubble", 32'(busy), 32'h1);
    end
    chk("rr_after", 32'(gnt), 32'h2);

    // Pointer wrap: owner 3 releases with only 0 pending
    do_reset();
    req = 4'b1000;
    tick();
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    push(dv[3]);
    tick();
    req = 4'b0001;
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_sel0", 32'(sel), 32'h0);
    req = 4'b1001;
    push(dv[0]);
    tick();
    chk("wrap_hold0", 32'(gnt), 32'h1);
    req = 4'b1000;
    tick();
    chk("wrap_back3", 32'(gnt), 32'h8);
    chk("wrap_sel3", 32'(sel), 32'h3);

    // Release to idle, result holds
    do_reset();
    req = 4'b0010;
    tick();
    dv[1] = 8'h5A;
    push(8'h5A);
    tick();
    req = 4'b0000;
    dv[1] = 8'hC3;
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_rvld", 32'(result_valid), 32'h0);
    chk("idle_result", 32'(result), 32'h5A);
    chk("idle_sel", 32'(sel), 32'h1);
    tick();
    chk("idle_result2", 32'(result), 32'h5A);
    chk("idle_gnt2", 32'(gnt), 32'h0);

    // Async reset mid-grant
    do_reset();
    req = 4'b0010;
    tick();
    push(8'hC3);
    tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_sel", 32'(sel), 32'h0);
    chk("arst_result", 32'(result), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_rvld", 32'(result_valid), 32'h0);
    tick();
    chk("arst_gnt_held", 32'(gnt), 32'h0);
    rst = 1'b0;
    req = 4'b0110;
    tick();
    chk("arst_regnt", 32'(gnt), 32'h2);
    chk("arst_resel", 32'(sel), 32'h1);

    // Long ownership with two requesters
    do_reset();
    req = 4'b0011;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int r = 0; r < 4; r++) begin
      o = r % 2;
      for (int c = 0; c < 4; c++) begin
        chk("to_gnt", 32'(gnt), 32'(4'b0001 << o));
        push(dv[o]);
        tick();
      end
    end
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("to_sole_gnt", 32'(gnt), 32'h1);
      push(dv[0]);
      tick();
    end
`else
    for (int c = 0; c < 10; c++) begin
      chk("hold_gnt", 32'(gnt), 32'h1);
      push(dv[0]);
      tick();
    end
`endif

    req = 4'b0000;
    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
